// File: rtl/mealy_mon_pkg.sv
// -----------------------------------------------------------------------------
// mealy_mon_pkg
//   Shared definitions for the Mealy pulse-window monitor:
//     - fsm_state_t : window FSM encoding (IDLE / RUN / REPORT)
//     - SYNC_STAGES : depth of the input synchroniser
//     - sat_inc()   : saturating increment for counters up to 32 bits wide
// -----------------------------------------------------------------------------
package mealy_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } fsm_state_t;

  localparam int unsigned SYNC_STAGES = 2;

  // Returns value+1, clamped to the all-ones value of a 'width'-bit counter.
  // Callers cast the 32-bit result back down to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] max_val;
    if (width >= 32) begin
      max_val = '1;
    end else begin
      max_val = (32'd1 << width) - 32'd1;
    end
    if (value >= max_val) begin
      return max_val;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/mealy_pulse_window_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
//   Brings an asynchronous single-bit signal into the clk domain through a
//   SYNC_STAGES-deep flop chain, then keeps one previous-value flop so that
//   edges of the synchronised level can be detected.
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-low reset, clears every flop
//   din     in   asynchronous input
//   level   out  synchronised level
//   rise    out  level & ~previous  (one cycle per 0->1 transition)
//   toggle  out  level ^ previous   (one cycle per transition, either edge)
// -----------------------------------------------------------------------------
module sync_edge
  import mealy_mon_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic toggle
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise   = level & ~prev_q;
  assign toggle = level ^ prev_q;

endmodule

// File: rtl/mealy_pulse_window.sv
// -----------------------------------------------------------------------------
// mealy_pulse_window
//   Counts rising edges of the (asynchronous) Mealy recogniser output over
//   fixed windows of WINDOW clk cycles and publishes each window's count with
//   a one-cycle valid strobe.
//
// Optional build macro: MEALY_STATE_HIST_EN
//   Defined   : state_in is synchronised too, and its toggles (either edge) are
//               counted per window and published on state_cnt with count.
//   Undefined : no state_in logic is built and state_cnt is tied to 0.
//
// Parameters
//   CNT_W   width of the event counter and of count/state_cnt
//   WINDOW  window length in clk cycles (2..65535)
//   WIN_W   width of the window counter, 2**WIN_W >= WINDOW
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   en         in   window enable (synchronous); dropping it in RUN aborts
//   out_in     in   Mealy out, asynchronous to clk
//   state_in   in   Mealy state, asynchronous to clk
//   count      out  event count of the last completed window
//   valid      out  one-cycle strobe, high while count is freshly updated
//   ovf        out  last completed window saturated its event counter
//   busy       out  high in RUN and REPORT
//   state_cnt  out  state_in toggle count of the last completed window
//
// Handshake: valid is a pure strobe with no ready; count/ovf/state_cnt change
// only on the edge that raises valid and hold until the next such edge.
// -----------------------------------------------------------------------------
module mealy_pulse_window #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned WINDOW = 1000,
  parameter int unsigned WIN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             out_in,
  input  logic             state_in,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             ovf,
  output logic             busy,
  output logic [CNT_W-1:0] state_cnt
);

  import mealy_mon_pkg::*;

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  fsm_state_t       state_q;
  fsm_state_t       state_d;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] evt_cnt;
  logic             sat;

  logic             evt;
  logic             win_last;
  logic             report_load;
  logic [CNT_W-1:0] evt_cnt_next;
  logic             sat_next;
  logic             unused_out_level;
  logic             unused_out_toggle;

  // ---------------------------------------------------------------------------
  // Input path for out_in
  // ---------------------------------------------------------------------------
  sync_edge u_out_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (out_in),
    .level  (unused_out_level),
    .rise   (evt),
    .toggle (unused_out_toggle)
  );

  assign win_last = (win_cnt == WIN_LAST);

  // Value evt_cnt takes if this cycle is sampled into the current window.
  // The sat flag is sticky: once an increment is clamped, the window reports
  // overflow even though the counter itself no longer moves.
  assign evt_cnt_next = evt ? CNT_W'(sat_inc(32'(evt_cnt), CNT_W)) : evt_cnt;
  assign sat_next     = sat | (evt & (evt_cnt == {CNT_W{1'b1}}));

  // The window closes on the edge leaving RUN for REPORT; the last RUN
  // cycle's event is folded in through evt_cnt_next.
  assign report_load  = (state_q == RUN) && (state_d == REPORT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. An en drop in RUN wins over the window boundary; REPORT
  // never aborts and only uses en to choose between another window and IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (win_last) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        state_d = en ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy  = 1'b0;
    valid = 1'b0;
    case (state_q)
      RUN: begin
        busy = 1'b1;
      end
      REPORT: begin
        busy  = 1'b1;
        valid = 1'b1;
      end
      default: begin
        busy  = 1'b0;
        valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Window and event counters.
  // The REPORT cycle is the first sample of the next window, so restart at
  // win_cnt=1 and seed evt_cnt with this cycle's event. Back-to-back windows
  // then stay exactly WINDOW cycles long.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt <= '0;
      evt_cnt <= '0;
      sat     <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (!en) begin
            win_cnt <= '0;
            evt_cnt <= '0;
            sat     <= 1'b0;
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            evt_cnt <= evt_cnt_next;
            sat     <= sat_next;
          end
        end
        REPORT: begin
          if (en) begin
            win_cnt <= WIN_W'(1);
            evt_cnt <= evt ? CNT_W'(1) : '0;
          end else begin
            win_cnt <= '0;
            evt_cnt <= '0;
          end
          sat <= 1'b0;
        end
        default: begin
          win_cnt <= '0;
          evt_cnt <= '0;
          sat     <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Published results: change only when a window completes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (report_load) begin
      count <= evt_cnt_next;
      ovf   <= sat_next;
    end
  end

`ifdef MEALY_STATE_HIST_EN
  // ---------------------------------------------------------------------------
  // state_in toggle histogram, following the same window/restart rules as
  // the event counter.
  // ---------------------------------------------------------------------------
  logic             tog;
  logic [CNT_W-1:0] tog_cnt;
  logic [CNT_W-1:0] tog_cnt_next;
  logic             unused_state_level;
  logic             unused_state_rise;

  sync_edge u_state_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (state_in),
    .level  (unused_state_level),
    .rise   (unused_state_rise),
    .toggle (tog)
  );

  assign tog_cnt_next = tog ? CNT_W'(sat_inc(32'(tog_cnt), CNT_W)) : tog_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tog_cnt <= '0;
    end else begin
      case (state_q)
        RUN: begin
          tog_cnt <= en ? tog_cnt_next : '0;
        end
        REPORT: begin
          if (en) begin
            tog_cnt <= tog ? CNT_W'(1) : '0;
          end else begin
            tog_cnt <= '0;
          end
        end
        default: begin
          tog_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_cnt <= '0;
    end else if (report_load) begin
      state_cnt <= tog_cnt_next;
    end
  end
`else
  logic unused_state_in;

  assign unused_state_in = state_in;
  assign state_cnt       = '0;
`endif

endmodule

// File: tb/tb_mealy_pulse_window.sv
// -----------------------------------------------------------------------------
// tb_mealy_pulse_window
//   Directed bench for mealy_pulse_window. dut uses WINDOW=8, CNT_W=3;
//   dut_sat uses a 24-cycle window so that more than seven rising edges fit
//   into one window and the event counter can saturate.
//   Expected window reports of dut are queued as {ovf, count, state_cnt} when
//   the stimulus is driven and popped whenever dut raises valid.
// -----------------------------------------------------------------------------
module tb_mealy_pulse_window;

  localparam int CNT_W      = 3;
  localparam int WINDOW     = 8;
  localparam int WIN_W      = 4;
  localparam int SAT_WINDOW = 24;
  localparam int SAT_WIN_W  = 5;
  localparam int EXP_W      = 1 + 2 * CNT_W;

`ifdef MEALY_STATE_HIST_EN
  localparam logic [CNT_W-1:0] HIST4 = 3'd4;
`else
  localparam logic [CNT_W-1:0] HIST4 = 3'd0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  logic             en, out_in, state_in;
  logic [CNT_W-1:0] count, state_cnt;
  logic             valid, ovf, busy;

  logic             en2, out2;
  logic [CNT_W-1:0] count2, state_cnt2;
  logic             valid2, ovf2, busy2;

  mealy_pulse_window #(.CNT_W(CNT_W), .WINDOW(WINDOW), .WIN_W(WIN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .out_in    (out_in),
    .state_in  (state_in),
    .count     (count),
    .valid     (valid),
    .ovf       (ovf),
    .busy      (busy),
    .state_cnt (state_cnt)
  );

  mealy_pulse_window #(.CNT_W(CNT_W), .WINDOW(SAT_WINDOW), .WIN_W(SAT_WIN_W)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .en        (en2),
    .out_in    (out2),
    .state_in  (1'b0),
    .count     (count2),
    .valid     (valid2),
    .ovf       (ovf2),
    .busy      (busy2),
    .state_cnt (state_cnt2)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (rst === 1'b1 && valid === 1'b1) begin
      check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_count", 32'(count), 32'(e[2*CNT_W-1:CNT_W]));
        check("sb_ovf", 32'(ovf), 32'(e[2*CNT_W]));
        check("sb_state_cnt", 32'(state_cnt), 32'(e[CNT_W-1:0]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  // Advance to 1 time unit after posedge number e.
  task automatic goto(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int s, b, c, d;
    rst = 1'b1; en = 1'b0; out_in = 1'b0; state_in = 1'b0; en2 = 1'b0; out2 = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state_cnt", 32'(state_cnt), 32'd0);
    check("rst_busy_sat", 32'(busy2), 32'd0);

    goto(2);
    rst = 1'b1;
    goto(4);
    check("idle_no_en_busy", 32'(busy), 32'd0);

    // Saturation on dut_sat: nine rises in one 24-cycle window.
    s = cyc;
    en2 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      goto(s + 2 * k);
      out2 = 1'b1;
      goto(s + 2 * k + 1);
      out2 = 1'b0;
    end
    goto(s + 24);
    check("sat_valid_before", 32'(valid2), 32'd0);
    goto(s + 25);
    check("sat_valid", 32'(valid2), 32'd1);
    check("sat_count", 32'(count2), 32'd7);
    check("sat_ovf", 32'(ovf2), 32'd1);
    goto(s + 26);
    check("sat_valid_one_cycle", 32'(valid2), 32'd0);
    goto(s + 49);
    check("sat_next_valid", 32'(valid2), 32'd1);
    check("sat_next_count", 32'(count2), 32'd0);
    check("sat_next_ovf", 32'(ovf2), 32'd0);
    en2 = 1'b0;
    goto(s + 51);
    check("sat_idle_busy", 32'(busy2), 32'd0);

    // Three clean 2-cycle pulses, then an empty window.
    b = cyc;
    exp_q.push_back({1'b0, 3'd3, 3'd0});
    exp_q.push_back({1'b0, 3'd0, 3'd0});
    en = 1'b1; out_in = 1'b1;
    goto(b + 1);
    check("run_busy", 32'(busy), 32'd1);
    goto(b + 2); out_in = 1'b0;
    goto(b + 3); out_in = 1'b1;
    goto(b + 5); out_in = 1'b0;
    goto(b + 6); out_in = 1'b1;
    goto(b + 8); out_in = 1'b0;
    check("w1_no_valid_yet", 32'(valid), 32'd0);
    goto(b + 9);
    check("w1_valid", 32'(valid), 32'd1);
    check("w1_busy_report", 32'(busy), 32'd1);
    goto(b + 10);
    check("w1_valid_drops", 32'(valid), 32'd0);
    goto(b + 16);
    check("w2_no_valid_early", 32'(valid), 32'd0);
    goto(b + 17);
    check("w2_valid_8_later", 32'(valid), 32'd1);

    // Boundary: event on win_cnt==7 stays in window 3; event in REPORT of
    // window 4 belongs to window 5.
    exp_q.push_back({1'b0, 3'd1, 3'd0});
    exp_q.push_back({1'b0, 3'd0, 3'd0});
    exp_q.push_back({1'b0, 3'd1, 3'd0});
    goto(b + 22); out_in = 1'b1;
    goto(b + 23); out_in = 1'b0;
    goto(b + 25);
    check("w3_valid", 32'(valid), 32'd1);
    goto(b + 31); out_in = 1'b1;
    goto(b + 32); out_in = 1'b0;
    goto(b + 33);
    check("w4_valid", 32'(valid), 32'd1);
    goto(b + 41);
    check("w5_valid", 32'(valid), 32'd1);

    // Abort: two pulses, en drops at win_cnt==4.
    out_in = 1'b1;
    goto(b + 42); out_in = 1'b0;
    goto(b + 43); out_in = 1'b1;
    goto(b + 44); out_in = 1'b0;
    goto(b + 45); en = 1'b0;
    goto(b + 46);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_count_kept", 32'(count), 32'd1);
    check("abort_ovf_kept", 32'(ovf), 32'd0);
    goto(b + 52);
    check("abort_still_idle", 32'(busy), 32'd0);
    check("abort_count_still", 32'(count), 32'd1);

    // Reset mid-RUN, then release with en=1 and toggle state_in four times.
    c = cyc;
    en = 1'b1;
    goto(c + 3);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_valid", 32'(valid), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_ovf", 32'(ovf), 32'd0);
    goto(c + 5);
    check("held_rst_busy", 32'(busy), 32'd0);
    d = cyc;
    exp_q.push_back({1'b0, 3'd0, HIST4});
    rst = 1'b1; state_in = 1'b1;
    check("release_busy", 32'(busy), 32'd0);
    goto(d + 1);
    check("release_run_busy", 32'(busy), 32'd1);
    goto(d + 2); state_in = 1'b0;
    goto(d + 4); state_in = 1'b1;
    goto(d + 6); state_in = 1'b0;
    goto(d + 8);
    check("post_rst_no_valid", 32'(valid), 32'd0);
    goto(d + 9);
    check("post_rst_valid", 32'(valid), 32'd1);
    en = 1'b0;
    goto(d + 11);
    check("final_idle_busy", 32'(busy), 32'd0);
    check("final_state_cnt", 32'(state_cnt), 32'(HIST4));
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
